// File: rtl/dwt53_pkg.sv
// Shared types and helpers for the streaming LeGall 5/3 DWT cascade.
// Contents: per-stage FSM state enum, level-count limit, sign-extension helper.
package dwt53_pkg;

  typedef enum logic [1:0] {
    S_EVEN0 = 2'd0,
    S_ODD   = 2'd1,
    S_EVEN  = 2'd2
  } stage_state_e;

  localparam int unsigned MAX_LEVELS = 4;
  localparam int unsigned MAX_W      = 32;

  // Sign-extends the low w bits of x to MAX_W bits; callers truncate to OW.
  function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] x,
                                                input int unsigned     w);
    logic signed [MAX_W-1:0] t;
    t = signed'(x << (MAX_W - w));
    return unsigned'(t >>> (MAX_W - w));
  endfunction

endpackage

// File: rtl/dwt53_if.sv
// Sample / coefficient bus of the DWT cascade.
// master: sample source + coefficient sink (drives in_*, observes results).
// slave : the transform (accepts in_*, drives hi_*, lo_*, err).
interface dwt53_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LEVELS = 2,
  parameter int unsigned OW     = DW + LEVELS
);
  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic                 in_last;
  logic [LEVELS-1:0]    hi_valid;
  logic [LEVELS*OW-1:0] hi_data;
  logic [LEVELS-1:0]    hi_last;
  logic                 lo_valid;
  logic [OW-1:0]        lo_data;
  logic                 lo_last;
  logic                 err;

  modport master (
    output in_valid, in_data, in_last,
    input  hi_valid, hi_data, hi_last, lo_valid, lo_data, lo_last, err
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output hi_valid, hi_data, hi_last, lo_valid, lo_data, lo_last, err
  );
endinterface

// File: rtl/dwt53_stage.sv
// One 5/3 lifting level: pairs even/odd samples, emits (s, d) registered.
// Ports: clk, rst (async active-low), in_valid_i/in_data_i[IW]/in_last_i,
//        pair_valid_o/pair_last_o (shared by lo and hi), lo_data_o[IW+1],
//        hi_data_o[IW+1], err_c_o (combinational frame-length error pulse).
module dwt53_stage
  import dwt53_pkg::*;
#(
  parameter int unsigned IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [IW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          pair_valid_o,
  output logic          pair_last_o,
  output logic [IW:0]   lo_data_o,
  output logic [IW:0]   hi_data_o,
  output logic          err_c_o
);

  localparam int unsigned XW = IW + 1;
  localparam int unsigned SW = IW + 3;

  stage_state_e         state_q;
  logic                 first_q;
  logic signed [IW-1:0] xe_q, xo_q;
  logic signed [XW-1:0] dp_q;
  logic                 pair_valid_q, pair_last_q;
  logic signed [XW-1:0] lo_q, hi_q;

  logic signed [IW-1:0] x_d, odd_d, right_d;
  logic signed [XW-1:0] pair_sum_d, d_d, dp_eff_d, s_d;
  logic signed [SW-1:0] upd_d;

  // Lifting datapath; in S_ODD the incoming sample is the frame's final odd
  // sample, so its right neighbour is mirrored to xe.
  always_comb begin
    x_d        = signed'(in_data_i);
    odd_d      = (state_q == S_ODD) ? x_d : xo_q;
    right_d    = (state_q == S_ODD) ? xe_q : x_d;
    pair_sum_d = XW'(xe_q) + XW'(right_d);
    d_d        = XW'(odd_d) - (pair_sum_d >>> 1);
    dp_eff_d   = first_q ? d_d : dp_q;
    upd_d      = SW'(dp_eff_d) + SW'(d_d) + SW'(2);
    s_d        = XW'(xe_q) + XW'(upd_d >>> 2);
    err_c_o    = in_valid_i && in_last_i && (state_q != S_ODD);
  end

  // Stage FSM and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_EVEN0;
      first_q      <= 1'b1;
      xe_q         <= '0;
      xo_q         <= '0;
      dp_q         <= '0;
      pair_valid_q <= 1'b0;
      pair_last_q  <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
    end else begin
      pair_valid_q <= 1'b0;
      pair_last_q  <= 1'b0;
      if (in_valid_i) begin
        case (state_q)
          S_EVEN0: begin
            if (!in_last_i) begin
              xe_q    <= x_d;
              first_q <= 1'b1;
              state_q <= S_ODD;
            end
          end
          S_ODD: begin
            if (!in_last_i) begin
              xo_q    <= x_d;
              state_q <= S_EVEN;
            end else begin
              pair_valid_q <= 1'b1;
              pair_last_q  <= 1'b1;
              lo_q         <= s_d;
              hi_q         <= d_d;
              state_q      <= S_EVEN0;
            end
          end
          S_EVEN: begin
            pair_valid_q <= 1'b1;
            lo_q         <= s_d;
            hi_q         <= d_d;
            if (in_last_i) begin
              // Odd-length frame: pair still emitted, frame abandoned.
              state_q <= S_EVEN0;
            end else begin
              dp_q    <= d_d;
              xe_q    <= x_d;
              first_q <= 1'b0;
              state_q <= S_ODD;
            end
          end
          default: state_q <= S_EVEN0;
        endcase
      end
    end
  end

  assign pair_valid_o = pair_valid_q;
  assign pair_last_o  = pair_last_q;
  assign lo_data_o    = unsigned'(lo_q);
  assign hi_data_o    = unsigned'(hi_q);

endmodule

// File: rtl/dwt53_cascade.sv
// Streaming 1-D LeGall 5/3 DWT, LEVELS cascaded lifting stages.
// Ports: clk, rst (async active-low), bus (dwt53_if.slave): in_* samples in,
//        per-level hi_* coefficients, final-level lo_* coefficients, err pulse.
module dwt53_cascade
  import dwt53_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned LEVELS = 2,
  parameter int unsigned OW     = DW + LEVELS
) (
  input logic     clk,
  input logic     rst,
  dwt53_if.slave  bus
);

  if (LEVELS < 1 || LEVELS > MAX_LEVELS) begin : g_bad_levels
    $error("dwt53_cascade: LEVELS out of range");
  end

  logic [OW-1:0] lo_ext [LEVELS];
  logic [OW-1:0] hi_ext [LEVELS];
  logic          pv     [LEVELS];
  logic          pl     [LEVELS];
  logic          ev     [LEVELS];
  logic          err_any_d;
  logic          err_q;

  // Level k consumes the low band of level k-1 (or the input stream at k=0).
  for (genvar k = 0; k < int'(LEVELS); k++) begin : g_lvl
    localparam int unsigned IW = DW + k;
    logic          in_v, in_l;
    logic [IW-1:0] in_d;
    logic [IW:0]   lo_w, hi_w;

    if (k == 0) begin : g_src
      assign in_v = bus.in_valid;
      assign in_d = bus.in_data;
      assign in_l = bus.in_last;
    end else begin : g_chain
      assign in_v = pv[k-1];
      assign in_d = lo_ext[k-1][IW-1:0];
      assign in_l = pl[k-1];
    end

    dwt53_stage #(.IW(IW)) u_stage (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_v),
      .in_data_i    (in_d),
      .in_last_i    (in_l),
      .pair_valid_o (pv[k]),
      .pair_last_o  (pl[k]),
      .lo_data_o    (lo_w),
      .hi_data_o    (hi_w),
      .err_c_o      (ev[k])
    );

    assign lo_ext[k] = OW'(sign_ext(MAX_W'(lo_w), IW + 1));
    assign hi_ext[k] = OW'(sign_ext(MAX_W'(hi_w), IW + 1));
  end

  // Output packing and error collection.
  always_comb begin
    bus.hi_valid = '0;
    bus.hi_last  = '0;
    bus.hi_data  = '0;
    err_any_d    = 1'b0;
    for (int k = 0; k < int'(LEVELS); k++) begin
      bus.hi_valid[k]          = pv[k];
      bus.hi_last[k]           = pl[k];
      bus.hi_data[k*OW +: OW]  = hi_ext[k];
      err_any_d                = err_any_d | ev[k];
    end
    bus.lo_valid = pv[LEVELS-1];
    bus.lo_last  = pl[LEVELS-1];
    bus.lo_data  = lo_ext[LEVELS-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_any_d;
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_dwt53_cascade.sv
// Bench: one-level and two-level cascades driven by the same stream, checked
// against a queue-based arithmetic model of the 5/3 lifting equations.
module tb_dwt53_cascade;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dwt53_if #(.DW(DW), .LEVELS(1)) b1 ();
  dwt53_if #(.DW(DW), .LEVELS(2)) b2 ();

  dwt53_cascade #(.DW(DW), .LEVELS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  dwt53_cascade #(.DW(DW), .LEVELS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  typedef struct { int data; bit last; } coef_t;
  typedef int iq_t[$];

  coef_t q1_hi[$], q1_lo[$], q2_hi0[$], q2_hi1[$], q2_lo[$];
  int checks = 0, errors = 0;
  int err1_seen = 0, err2_seen = 0, err1_exp = 0, err2_exp = 0;

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic coef_t mk(int d, bit l);
    coef_t c;
    c.data = d;
    c.last = l;
    return c;
  endfunction

  // Reference lifting of one whole even-length frame with mirrored ends.
  function automatic void lift(input iq_t x, output iq_t s, output iq_t d);
    int n, right, dm;
    n = x.size() / 2;
    s = {};
    d = {};
    for (int i = 0; i < n; i++) begin
      right = (2*i + 2 < x.size()) ? x[2*i+2] : x[2*i];
      d.push_back(x[2*i+1] - ((x[2*i] + right) >>> 1));
    end
    for (int i = 0; i < n; i++) begin
      dm = (i == 0) ? d[0] : d[i-1];
      s.push_back(x[2*i] + ((dm + d[i] + 2) >>> 2));
    end
  endfunction

  function automatic void expect_frame(input iq_t x);
    iq_t s0, d0, s1, d1;
    lift(x, s0, d0);
    for (int i = 0; i < d0.size(); i++) begin
      q1_hi.push_back(mk(d0[i], i == d0.size() - 1));
      q1_lo.push_back(mk(s0[i], i == d0.size() - 1));
      q2_hi0.push_back(mk(d0[i], i == d0.size() - 1));
    end
    lift(s0, s1, d1);
    for (int i = 0; i < d1.size(); i++) begin
      q2_hi1.push_back(mk(d1[i], i == d1.size() - 1));
      q2_lo.push_back(mk(s1[i], i == d1.size() - 1));
    end
  endfunction

  task automatic drive(bit v, int d, bit l);
    @(negedge clk);
    b1.in_valid = v; b1.in_data = DW'(d); b1.in_last = l;
    b2.in_valid = v; b2.in_data = DW'(d); b2.in_last = l;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  // Gaps only before non-first samples, so consecutive frames stay back-to-back.
  task automatic send_frame(input iq_t x, bit gaps);
    for (int i = 0; i < x.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      drive(1'b1, x[i], i == x.size() - 1);
    end
  endtask

  function automatic iq_t rand_frame(int quads);
    iq_t x;
    x = {};
    for (int i = 0; i < 4 * quads; i++) x.push_back(int'($urandom_range(0, 255)) - 128);
    return x;
  endfunction

  // Scoreboard: every valid coefficient must match the next expected one.
  always @(negedge clk) begin
    coef_t e;
    if (b1.hi_valid[0]) begin
      if (q1_hi.size() == 0) chk("l1_hi_extra", 1, 0);
      else begin
        e = q1_hi.pop_front();
        chk("l1_hi", 32'($signed(b1.hi_data)), e.data);
        chk("l1_hi_last", 32'(b1.hi_last[0]), 32'(e.last));
      end
    end
    if (b1.lo_valid) begin
      if (q1_lo.size() == 0) chk("l1_lo_extra", 1, 0);
      else begin
        e = q1_lo.pop_front();
        chk("l1_lo", 32'($signed(b1.lo_data)), e.data);
        chk("l1_lo_last", 32'(b1.lo_last), 32'(e.last));
      end
    end
    if (b2.hi_valid[0]) begin
      if (q2_hi0.size() == 0) chk("l2_hi0_extra", 1, 0);
      else begin
        e = q2_hi0.pop_front();
        chk("l2_hi0", 32'($signed(b2.hi_data[9:0])), e.data);
        chk("l2_hi0_last", 32'(b2.hi_last[0]), 32'(e.last));
      end
    end
    if (b2.hi_valid[1]) begin
      if (q2_hi1.size() == 0) chk("l2_hi1_extra", 1, 0);
      else begin
        e = q2_hi1.pop_front();
        chk("l2_hi1", 32'($signed(b2.hi_data[19:10])), e.data);
        chk("l2_hi1_last", 32'(b2.hi_last[1]), 32'(e.last));
      end
    end
    if (b2.lo_valid) begin
      if (q2_lo.size() == 0) chk("l2_lo_extra", 1, 0);
      else begin
        e = q2_lo.pop_front();
        chk("l2_lo", 32'($signed(b2.lo_data)), e.data);
        chk("l2_lo_last", 32'(b2.lo_last), 32'(e.last));
      end
    end
    if (b1.err === 1'b1) err1_seen++;
    if (b2.err === 1'b1) err2_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    iq_t fa, fb;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_l1_lo_valid", 32'(b1.lo_valid), 0);
    chk("rst_l1_hi_valid", 32'(b1.hi_valid), 0);
    chk("rst_l1_lo_data", 32'(b1.lo_data), 0);
    chk("rst_l2_hi_data", 32'(b2.hi_data), 0);
    chk("rst_l2_hi_last", 32'(b2.hi_last), 0);
    chk("rst_l2_err", 32'(b2.err), 0);
    rst = 1'b1;
    idle(2);

    // Directed frame 10,40,20,50.
    q1_hi.push_back(mk(25, 0)); q1_hi.push_back(mk(30, 1));
    q1_lo.push_back(mk(23, 0)); q1_lo.push_back(mk(34, 1));
    q2_hi0.push_back(mk(25, 0)); q2_hi0.push_back(mk(30, 1));
    q2_hi1.push_back(mk(11, 1)); q2_lo.push_back(mk(29, 1));
    drive(1, 10, 0); drive(1, 40, 0); drive(1, 20, 0); drive(1, 50, 1);
    drive(0, 0, 0);
    chk("l1_latency_last", 32'(b1.lo_valid && b1.lo_last), 1);
    drive(0, 0, 0);
    chk("l2_latency_last", 32'(b2.lo_valid && b2.lo_last), 1);
    idle(4);

    // Floor rounding: 0,0,-1,0.
    q1_hi.push_back(mk(1, 0)); q1_hi.push_back(mk(1, 1));
    q1_lo.push_back(mk(1, 0)); q1_lo.push_back(mk(0, 1));
    q2_hi0.push_back(mk(1, 0)); q2_hi0.push_back(mk(1, 1));
    q2_hi1.push_back(mk(-1, 1)); q2_lo.push_back(mk(1, 1));
    drive(1, 0, 0); drive(1, 0, 0); drive(1, -1, 0); drive(1, 0, 1);
    idle(4);

    // Odd-length frame, then a good frame. The two-level cascade's second
    // stage carries the stray 23 into the next frame and errs there.
    q1_hi.push_back(mk(25, 0)); q1_lo.push_back(mk(23, 0));
    q2_hi0.push_back(mk(25, 0));
    err1_exp++; err2_exp++;
    drive(1, 10, 0); drive(1, 40, 0); drive(1, 20, 1);
    idle(4);
    chk("l1_err_once", err1_seen, err1_exp);
    q1_hi.push_back(mk(25, 0)); q1_hi.push_back(mk(30, 1));
    q1_lo.push_back(mk(23, 0)); q1_lo.push_back(mk(34, 1));
    q2_hi0.push_back(mk(25, 0)); q2_hi0.push_back(mk(30, 1));
    q2_hi1.push_back(mk(-5, 0)); q2_lo.push_back(mk(21, 0));
    err2_exp++;
    drive(1, 10, 0); drive(1, 40, 0); drive(1, 20, 0); drive(1, 50, 1);
    idle(6);
    chk("l1_err_count", err1_seen, err1_exp);
    chk("l2_err_count", err2_seen, err2_exp);

    // Random back-to-back frame pairs with random input gaps.
    for (int r = 0; r < 8; r++) begin
      fa = rand_frame(int'($urandom_range(1, 6)));
      fb = rand_frame(int'($urandom_range(1, 6)));
      expect_frame(fa);
      expect_frame(fb);
      send_frame(fa, 1'b1);
      send_frame(fb, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(6);

    // Asynchronous reset mid-frame while a pair is on the outputs.
    q1_hi.push_back(mk(25, 0)); q1_lo.push_back(mk(23, 0));
    q2_hi0.push_back(mk(25, 0));
    drive(1, 10, 0); drive(1, 40, 0); drive(1, 20, 0);
    drive(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_l1_lo_valid", 32'(b1.lo_valid), 0);
    chk("arst_l1_lo_data", 32'(b1.lo_data), 0);
    chk("arst_l1_hi_data", 32'(b1.hi_data), 0);
    chk("arst_l2_hi_valid", 32'(b2.hi_valid), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    fa = rand_frame(3);
    expect_frame(fa);
    send_frame(fa, 1'b1);
    idle(8);

    chk("end_l1_err", err1_seen, err1_exp);
    chk("end_l2_err", err2_seen, err2_exp);
    chk("end_q1_hi", q1_hi.size(), 0);
    chk("end_q1_lo", q1_lo.size(), 0);
    chk("end_q2_hi0", q2_hi0.size(), 0);
    chk("end_q2_hi1", q2_hi1.size(), 0);
    chk("end_q2_lo", q2_lo.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dwt53_cascade.md
Name: dwt53_cascade

Overview:
- Streaming 1-D integer LeGall 5/3 lifting DWT.
- Decomposition depth (LEVELS) and sample width (DW) are parameters.
- Each level splits its input into a high band (detail) and a low band (approximation). The low band feeds the next level. All high bands and the final low band are output.
- Frames are delimited by in_last. Symmetric boundary extension is applied at both frame ends.
- Sits between the sample source (ROM or ADC stream) and the coefficient consumer. Generalises the fixed 8-bit, two-level lifting datapath.

Parameters:
- DW, 8: input sample width, signed two's complement.
- LEVELS, 2: number of cascaded decomposition levels, 1..4.
- OW, DW+LEVELS: output coefficient width. All outputs are sign-extended to OW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input sample valid.
- in_data  in  DW  input sample, signed.
- in_last  in  1  qualifies the final sample of a frame.
- hi_valid  out  LEVELS  per-level high-band coefficient valid.
- hi_data  out  LEVELS*OW  per-level high-band coefficients. Level k occupies bits [k*OW +: OW].
- hi_last  out  LEVELS  per-level last coefficient of frame.
- lo_valid  out  1  final-level low-band valid.
- lo_data  out  OW  final-level low-band coefficient.
- lo_last  out  1  last low-band coefficient of frame.
- err  out  1  one-cycle pulse on a frame-length violation at any level.

Behaviour:
- No backpressure. A sink must accept every valid cycle. in_valid may have arbitrary gaps.
- Level k input width is IW = DW+k; its output width is IW+1.
- Level 0 is driven by in_*. Level k>0 is driven by level k-1's lo outputs: lo_valid→in_valid, lo_data→in_data, lo_last→in_last.
- Arithmetic is signed. ">>>" is an arithmetic shift, i.e. floor division.
  - d[n] = x[2n+1] - ((x[2n] + x[2n+2]) >>> 1), with the sum in IW+1 bits.
  - s[n] = x[2n] + ((d[n-1] + d[n] + 2) >>> 2), with the sum in IW+3 bits, result truncated to IW+1 bits.
- Boundary conditions:
  - Left: d[-1] = d[0].
  - Right: for the final odd sample x[N-1], use x[N] = x[N-2], so d = x[N-1] - x[N-2].
- Stage FSM, per level:
  - S_EVEN0 (expect x[0]): accept → xe<=x, first<=1, go to S_ODD. If in_last is set: err pulse, stay in S_EVEN0.
  - S_ODD (expect odd sample), in_last=0: xo<=x, go to S_EVEN.
  - S_ODD, in_last=1: compute the final pair using the right mirror (and first ? d : dp as d[n-1]). Emit s,d with last=1. Go to S_EVEN0.
  - S_EVEN (expect x[2n+2]): compute d, s using xo, xe, x, and dp_eff = first ? d : dp. Emit pair. Then dp<=d, xe<=x, first<=0, go to S_ODD.
  - S_EVEN with in_last=1 (odd-length frame): the pair computed this cycle is still emitted, with last=0. err pulse, go to S_EVEN0.
- Latency:
  - A pair is registered and appears 1 cycle after the accept that completes it.
  - lo and hi of the same pair are valid in the same cycle.
  - The final lo at level L-1 trails the completing input by LEVELS cycles in the best case.
- Frame length N must be divisible by 2^LEVELS. Otherwise some level reports err and its frame is abandoned.
- err = OR of all stage error pulses, registered, one cycle wide.
- Frames are back-to-back capable. An input accepted in the cycle after a last is x[0] of the next frame.
- Reset (any time, including mid-frame):
  - All valids, lasts and err go to 0; all data outputs go to 0.
  - FSMs go to S_EVEN0; xe, xo, dp go to 0; first goes to 1.
  - A partial frame is discarded with no output.
- Valid outputs hold their data for exactly one cycle. Data outputs are don't-care while invalid but must not glitch the registered values.

Decomposition:
- Package dwt53_pkg:
  - stage state enum (S_EVEN0, S_ODD, S_EVEN);
  - MAX_LEVELS=4 constant;
  - function to sign-extend to OW.
- Sub-module dwt53_stage, parametrised by IW: the FSM, lifting datapath and output register for one level.
- Top dwt53_cascade:
  - generate loop instancing LEVELS stages;
  - sign-extension and packing of hi_*;
  - err OR-reduction register.

Test Plan:
- LEVELS=1, DW=8, frame 10,40,20,50 (last on 50) → pair at cycle after 20: lo=23, hi=25. Pair after 50: lo=34, hi=30, lo_last=hi_last=1.
- LEVELS=2, same frame → level-0 hi 25, 30. Level-1 input 23, 34 yields hi[1]=11, lo=29 with lo_last=1 and hi_last[1]=1.
- Floor rounding, LEVELS=1, frame 0,0,-1,0 → lo=1, hi=1; then lo=0, hi=1 with last (-1>>>1 = -1).
- Bad length, LEVELS=1, frame 10,40,20 with last on 20 → pair lo=23, hi=25 emitted with last=0, err pulses once, next frame 10,40,20,50 is correct.
- Gaps and back-to-back: two frames with random in_valid gaps and no idle between frames → coefficients identical to the gap-free golden model, one last per frame.
- rst asserted asynchronously mid-frame (after 10,40) → outputs 0 immediately; a new frame after release produces golden results with no residue from dp/xe.
